// File: rtl/rop_rng_pkg.sv
// Shared types and widths for the PRNG sample consumer.
//   state_t    : sampler FSM states
//   rng_word_t : 64-bit PRNG word viewed as {hi, lo} sample halves
package rop_rng_pkg;

  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned WORD_W   = 64;

  typedef enum logic {
    IDLE    = 1'b0,
    PUSH_HI = 1'b1
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] hi;
    logic [SAMPLE_W-1:0] lo;
  } rng_word_t;

endpackage

// File: rtl/rop_rng_fifo.sv
// Synchronous FIFO with registered storage and a combinational head view.
//   clk, resetn      : clock, async active-low reset (empties the FIFO)
//   push, push_data  : write request and data (ignored while full)
//   pop              : read request (ignored while empty)
//   count            : occupancy, 0..DEPTH
//   full, empty      : occupancy flags
//   head             : oldest entry, zero while empty
module rop_rng_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rop_rng_sampler.sv
// PRNG consumer: takes 64-bit words, splits them into two 32-bit samples in a
// FIFO, serves them over valid/ready and health-tests every consumed word.
//   clk, resetn  : clock, async active-low reset
//   rng_random   : current PRNG word
//   rng_en       : consume current word (PRNG advances on this edge)
//   samp_valid   : FIFO head available
//   samp_ready   : consumer accepts head
//   samp_data    : FIFO head sample
//   health_err   : sticky health-test failure
//   health_clr   : clear health_err and the repeat-detection history
module rop_rng_sampler
  import rop_rng_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [WORD_W-1:0]   rng_random,
  output logic                rng_en,
  output logic                samp_valid,
  input  logic                samp_ready,
  output logic [SAMPLE_W-1:0] samp_data,
  output logic                health_err,
  input  logic                health_clr
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  state_t              state_next;
  rng_word_t           word;
  logic [CW-1:0]       count;
  logic [CW-1:0]       free;
  logic                full;
  logic                empty;
  logic [SAMPLE_W-1:0] hi_hold;
  logic [WORD_W-1:0]   prev_word;
  logic                prev_valid;
  logic                push;
  logic [SAMPLE_W-1:0] push_data;
  logic                pop;
  logic                latch;
  logic                set_err;
  logic                fill_ok;
  logic                word_good;

  assign word       = rng_word_t'(rng_random);
  assign samp_valid = !empty;
  assign pop        = samp_valid && samp_ready;

  // Two free slots reserve room for both halves, judged before this cycle's pop.
  assign free      = CW'(FIFO_DEPTH) - count;
  assign fill_ok   = !full && (free >= CW'(2)) && !health_err && !health_clr;
  assign word_good = (!prev_valid || (rng_random != prev_word)) && (rng_random != '0);

  rop_rng_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .head      (samp_data)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and fill control; rng_en is qualified by resetn so it drops
  // the moment reset asserts.
  always_comb begin
    state_next = state;
    rng_en     = 1'b0;
    push       = 1'b0;
    push_data  = '0;
    latch      = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (resetn && fill_ok) begin
          if (word_good) begin
            rng_en     = 1'b1;
            push       = 1'b1;
            push_data  = word.lo;
            latch      = 1'b1;
            state_next = PUSH_HI;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      PUSH_HI: begin
        push       = 1'b1;
        push_data  = hi_hold;
        state_next = IDLE;
      end
    endcase
  end

  // High half, repeat history and sticky error; clear beats a same-cycle failure.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_hold    <= '0;
      prev_word  <= '0;
      prev_valid <= 1'b0;
      health_err <= 1'b0;
    end else begin
      if (latch) begin
        hi_hold   <= word.hi;
        prev_word <= rng_random;
      end
      if (health_clr)  prev_valid <= 1'b0;
      else if (latch)  prev_valid <= 1'b1;
      if (health_clr)   health_err <= 1'b0;
      else if (set_err) health_err <= 1'b1;
    end
  end

endmodule

// File: doc/rop_rng_sampler.md
Name: rop_rng_sampler

Overview:
Consumer side of the co-processor PRNG. Pulses `rng_en` to take each 64-bit `rng_random` word and splits it into two 32-bit samples in a small FIFO. Serves samples to the execute stage over a valid/ready handshake and runs a continuous health test on every consumed word. Sits between rop_prng and the random-sample instruction datapath.

Parameters:
FIFO_DEPTH, 4, number of 32-bit sample entries; power of two, >= 2.

Ports:
clk  input  1  global clock
resetn  input  1  asynchronous active-low reset
rng_random  input  64  current PRNG output word
rng_en  output  1  consume current word; PRNG advances on this edge
samp_valid  output  1  FIFO head sample available
samp_ready  input  1  consumer accepts head sample
samp_data  output  32  FIFO head sample
health_err  output  1  sticky health-test failure
health_clr  input  1  clear health_err and history

Behaviour:
- Reset is asynchronous and active-low on all state. While resetn=0: FIFO empty, count=0, rng_en=0, samp_valid=0, samp_data=0, health_err=0, prev_valid=0, FSM=IDLE.
- Free slots = FIFO_DEPTH - count. The count register is $clog2(FIFO_DEPTH)+1 bits wide. Read and write pointers wrap modulo FIFO_DEPTH.
- Pop occurs when samp_valid && samp_ready. samp_data is the head entry, registered FIFO storage, no bypass.
- FSM states:
  - IDLE: the word is good if prev_valid=0 or rng_random != prev_word, and rng_random != 0.
  - IDLE, fill condition (free >= 2, computed before this cycle's pop, health_err=0, health_clr=0): evaluate the health test.
  - IDLE, good word: rng_en=1 this cycle, push rng_random[31:0], latch hi_hold=rng_random[63:32], prev_word=rng_random, prev_valid=1, go to PUSH_HI.
  - IDLE, bad word: rng_en=0, no push, set health_err, stay IDLE.
  - PUSH_HI: push hi_hold (a slot is guaranteed, reserved in IDLE), rng_en=0, go to IDLE.
- rng_en is high for at most one cycle out of every two. Maximum fill rate is one sample per cycle.
- A push and a pop in the same cycle leave count unchanged. A pop while full is legal. A push never happens while full.
- health_err is sticky. While set, no fills occur, and the FIFO still drains normally; samples already queued are not flushed.
- health_clr (one cycle): clears health_err and prev_valid and suppresses the fill in that cycle. If it arrives in PUSH_HI, the hi push still completes.
- health_clr arriving in the same cycle as a failure: clear wins, and no error is set.
- Reset asserted mid-operation (e.g. in PUSH_HI): the pending hi half is discarded and the FIFO is emptied immediately (asynchronous).
- Latency: first sample valid one cycle after reset release, given the PRNG is running.

Decomposition:
- Shared package rop_rng_pkg: FSM state typedef (IDLE, PUSH_HI), sample width constant (32), word width constant (64).
- One sub-module: rop_rng_fifo, a synchronous FIFO parameterised by depth and width, exposing push, pop, count, full, empty and head.
- Sampler FSM, health test and hi_hold register stay in rop_rng_sampler.

Test Plan:
- Reset release with rop_prng attached (seed all-ones), samp_ready=1: samples are 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFF in order. rng_en pulses on cycles 0 and 2.
- samp_ready=0 after reset, FIFO_DEPTH=4: count saturates at 4, rng_en pulses exactly twice, then stays 0. Releasing samp_ready resumes fills once 2 slots free.
- Stuck source (rng_random forced to 0x0123456789ABCDEF): one good consume, then health_err=1 on the next IDLE evaluation, no further rng_en, FIFO drains the 2 queued samples.
- rng_random=0 at the first fill attempt: health_err=1 immediately, no push, samp_valid stays 0.
- health_err=1, pulse health_clr: err clears next cycle, prev_valid=0, fills resume the following cycle. Also check health_clr coincident with a failure leaves err=0.
- Assert resetn=0 asynchronously while in PUSH_HI with 3 entries queued: samp_valid and rng_en drop without a clock edge, count=0. After release, refill starts from the current rng_random.
